// File: rtl/switch_debounce_poller.sv
// Polls the slide-switch PIO once per POLL_DIV cycles, debounces the sampled value and
// presents debounced state, edge capture and a maskable interrupt on an Avalon-MM slave.
module switch_debounce_poller #(
  parameter int POLL_DIV   = 50000,
  parameter int STABLE_CNT = 4,
  parameter int WIDTH      = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDR   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  // IDLE covers POLL_DIV-3 cycles so that ADDR/SAMPLE/UPDATE close out exactly one period.
  localparam int DIV_W = (POLL_DIV > 4) ? $clog2(POLL_DIV - 3) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(POLL_DIV - 4);
  localparam logic [3:0]       STABLE_LIM = 4'(STABLE_CNT);

  logic [1:0]       state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [WIDTH-1:0] candidate_reg, candidate_next;
  logic [3:0]       stable_reg, stable_next;
  logic [WIDTH-1:0] debounced_reg, debounced_next;
  logic [WIDTH-1:0] edge_reg, edge_next;
  logic [WIDTH-1:0] irqmask_reg, irqmask_next;
  logic [15:0]      sample_count_reg, sample_count_next;
  logic [31:0]      readdata_reg, readdata_next;
  logic             irq_reg;

  logic             wr_en, rd_en, accept;
  logic [WIDTH-1:0] sample, set_mask, clr_mask;
  logic             unused_bits;

  assign unused_bits = &{1'b0, pio_readdata, writedata};

  assign wr_en  = chipselect & ~write_n;
  assign rd_en  = chipselect & write_n;
  assign sample = pio_readdata[WIDTH-1:0];

  assign pio_address = (state_reg == ST_ADDR || state_reg == ST_SAMPLE) ? 2'd0 : 2'd1;
  assign readdata    = readdata_reg;
  assign irq         = irq_reg;

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    case (state_reg)
      ST_IDLE: begin
        if (div_reg == DIV_LAST) begin
          state_next = ST_ADDR;
          div_next   = '0;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      ST_ADDR:   state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = ST_UPDATE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    candidate_next    = candidate_reg;
    stable_next       = stable_reg;
    sample_count_next = sample_count_reg;
    if (state_reg == ST_SAMPLE) begin
      sample_count_next = sample_count_reg + 16'd1;
      if (sample == candidate_reg) begin
        if (stable_reg < STABLE_LIM)
          stable_next = stable_reg + 4'd1;
      end else begin
        candidate_next = sample;
        stable_next    = 4'd1;
      end
    end
  end

  assign accept = (state_reg == ST_UPDATE) && (stable_reg == STABLE_LIM) &&
                  (candidate_reg != debounced_reg);
  assign debounced_next = accept ? candidate_reg : debounced_reg;
  assign set_mask       = accept ? (candidate_reg ^ debounced_reg) : '0;
  assign clr_mask       = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
  assign irqmask_next   = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : irqmask_reg;

  // A new edge outranks a simultaneous clear of the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_next[gi] = set_mask[gi] | (edge_reg[gi] & ~clr_mask[gi]);
    end
  endgenerate

  always_comb begin
    readdata_next = readdata_reg;
    if (rd_en) begin
      case (address)
        2'd0:    readdata_next = 32'(debounced_reg);
        2'd1:    readdata_next = 32'(irqmask_reg);
        2'd2:    readdata_next = 32'(edge_reg);
        default: readdata_next = {16'b0, sample_count_reg};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      div_reg          <= '0;
      candidate_reg    <= '0;
      stable_reg       <= '0;
      debounced_reg    <= '0;
      edge_reg         <= '0;
      irqmask_reg      <= '0;
      sample_count_reg <= '0;
      readdata_reg     <= '0;
      irq_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      div_reg          <= div_next;
      candidate_reg    <= candidate_next;
      stable_reg       <= stable_next;
      debounced_reg    <= debounced_next;
      edge_reg         <= edge_next;
      irqmask_reg      <= irqmask_next;
      sample_count_reg <= sample_count_next;
      readdata_reg     <= readdata_next;
      irq_reg          <= |(edge_reg & irqmask_reg);
    end
  end

endmodule
